radar_sim_sequencer: RTL and testbench
======================================

Name: radar_sim_sequencer

Overview:
- Run-control scheduler for the radar simulator.
- Consumes the measured turn statistics (ARP period, ACPs per turn, TRIG period, calibrated flag) and the synchronised ARP/ACP/TRIG/1 MHz edge pulses.
- Decides when simulation may start, tracks antenna azimuth and sweep index in real time, and issues per-turn and per-sweep strobes to the target generators.
- Watchdogs detect loss of ARP or TRIG and ACP-count anomalies, forcing a fault state.

Parameters:
- DATA_WIDTH, 32, width of statistic inputs, counters and index outputs.
- CAL_TURNS, 2, consecutive ARPs with CALIBRATED high required before arming (1..15).
- ACP_TOL, 1, allowed absolute deviation of per-turn ACP count from the latched reference.

Ports:
- SYS_CLK  in  1  PL system clock; all logic on posedge.
- SYS_RESETN  in  1  synchronous active-low reset.
- ENABLE  in  1  run request from software; level.
- ARP_PULSE  in  1  one-cycle ARP rising-edge strobe, SYS_CLK domain.
- ACP_PULSE  in  1  one-cycle ACP rising-edge strobe.
- TRIG_PULSE  in  1  one-cycle TRIG rising-edge strobe.
- US_TICK  in  1  one-cycle strobe per microsecond.
- CALIBRATED  in  1  statistics stable.
- ARP_US  in  DATA_WIDTH  measured ARP period, us.
- ACP_CNT  in  DATA_WIDTH  measured ACPs per turn.
- TRIG_US  in  DATA_WIDTH  measured TRIG period, us.
- STATE  out  3  0 IDLE, 1 WAIT_CAL, 2 WAIT_ARP, 3 RUN, 4 FAULT.
- RUNNING  out  1  high iff STATE==RUN.
- TURN_START  out  1  one-cycle strobe at each ARP in RUN, including entry.
- SWEEP_START  out  1  one-cycle strobe per TRIG in RUN.
- AZIMUTH  out  DATA_WIDTH  ACPs since last ARP.
- SWEEP_AZ  out  DATA_WIDTH  AZIMUTH captured with SWEEP_START.
- SWEEP_IDX  out  DATA_WIDTH  TRIGs since last ARP; value valid with SWEEP_START.
- FAULT_CODE  out  2  0 none, 1 ACP count, 2 ARP lost, 3 TRIG lost.

Behaviour:
- Reset (SYS_RESETN low at a clock edge): STATE=IDLE; every output and internal counter 0. Applies mid-RUN or mid-FAULT; takes effect on the same edge.
- All outputs are registered. Strobes occur one cycle after the causing input pulse.
- ENABLE low in any state: next cycle STATE=IDLE, strobes 0. FAULT_CODE is held while in IDLE.
- IDLE -> WAIT_CAL when ENABLE is high. FAULT_CODE cleared on this transition.
- WAIT_CAL:
  - On each ARP_PULSE: cal_cnt+1 if CALIBRATED, else cal_cnt=0.
  - When cal_cnt reaches CAL_TURNS -> WAIT_ARP.
  - Latch ARP_US, ACP_CNT and TRIG_US as references at that same ARP.
- WAIT_ARP: next ARP_PULSE -> RUN. Apply the turn-reset actions below, with no ACP check on this ARP.
- Turn reset (ARP in RUN, or entry to RUN):
  - AZIMUTH = 1 if ACP_PULSE is in the same cycle, else 0.
  - SWEEP_IDX counter = 0.
  - us_since_arp = 1 if US_TICK is in the same cycle, else 0.
  - TURN_START = 1.
- RUN, ARP_PULSE: compare the pre-ARP AZIMUTH against ref_acp ± ACP_TOL (unsigned; lower bound saturates at 0). Outside the window -> FAULT, code 1, no TURN_START.
- RUN, ACP_PULSE without ARP: AZIMUTH+1. If the result exceeds ref_acp+ACP_TOL -> FAULT, code 1, immediately.
- RUN, TRIG_PULSE:
  - SWEEP_START=1.
  - SWEEP_AZ = AZIMUTH value after this cycle's ARP/ACP update.
  - SWEEP_IDX = counter value after this cycle's ARP reset; then counter+1.
  - Simultaneous ARP+TRIG: SWEEP_IDX=0, sweep belongs to the new turn.
- Watchdogs (RUN only): us_since_arp and us_since_trig increment on US_TICK and saturate at all-ones.
  - us_since_trig restarts at 0, or 1 with simultaneous US_TICK, on TRIG_PULSE and on RUN entry.
  - ARP lost: us_since_arp > ref_arp + (ref_arp>>3), computed in DATA_WIDTH+1 bits -> FAULT, code 2.
  - TRIG lost: us_since_trig > 2*ref_trig, DATA_WIDTH+1 bits -> FAULT, code 3.
  - Priority when several faults fire in one cycle: 1 > 2 > 3.
- FAULT: all strobes 0; AZIMUTH and SWEEP_* frozen. Exit only via ENABLE low, or reset.
- References are not updated during RUN; re-arming requires passing through IDLE.

Test Plan:
- Bring-up: ARP_US=1000, ACP_CNT=16, TRIG_US=100, CALIBRATED=1, ARP every 1000 ticks, 16 evenly spaced ACPs, 10 TRIGs per turn, ENABLE=1 -> WAIT_CAL for 2 ARPs, WAIT_ARP for 1, then RUN. First TURN_START one cycle after the 4th ARP. SWEEP_IDX runs 0..9 each turn; AZIMUTH reaches 16 before each ARP; FAULT_CODE stays 0.
- CALIBRATED drops at the 2nd ARP -> cal_cnt resets; RUN entered only after two further consecutive calibrated ARPs.
- In RUN, deliver 14 ACPs in one turn -> FAULT, code 1, on that ARP; TURN_START absent. Separately, an 18th ACP -> FAULT, code 1, one cycle after it.
- Remove ARP after RUN entry -> FAULT, code 2, when us_since_arp reaches 1126. Remove TRIG only -> FAULT, code 3, at 201 us after the last TRIG.
- ARP, ACP, TRIG and US_TICK in the same cycle -> TURN_START=1, AZIMUTH=1, SWEEP_AZ=1, SWEEP_IDX=0, us_since_arp=1.
- SYS_RESETN low for 1 cycle mid-RUN -> next cycle STATE=0 and all outputs 0. ENABLE toggled low in FAULT -> IDLE with code held; ENABLE high -> code cleared and WAIT_CAL.

Source files
------------

// File: rtl/radar_sim_sequencer.sv
// Run-control scheduler for the radar simulator: arms on calibrated turn
// statistics, tracks azimuth and sweep index in RUN, and watches for lost
// ARP/TRIG and ACP count anomalies.
module radar_sim_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CAL_TURNS  = 2,
    parameter int unsigned ACP_TOL    = 1
) (
    input  logic                  SYS_CLK,
    input  logic                  SYS_RESETN,
    input  logic                  ENABLE,
    input  logic                  ARP_PULSE,
    input  logic                  ACP_PULSE,
    input  logic                  TRIG_PULSE,
    input  logic                  US_TICK,
    input  logic                  CALIBRATED,
    input  logic [DATA_WIDTH-1:0] ARP_US,
    input  logic [DATA_WIDTH-1:0] ACP_CNT,
    input  logic [DATA_WIDTH-1:0] TRIG_US,
    output logic [2:0]            STATE,
    output logic                  RUNNING,
    output logic                  TURN_START,
    output logic                  SWEEP_START,
    output logic [DATA_WIDTH-1:0] AZIMUTH,
    output logic [DATA_WIDTH-1:0] SWEEP_AZ,
    output logic [DATA_WIDTH-1:0] SWEEP_IDX,
    output logic [1:0]            FAULT_CODE
);

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [DATA_WIDTH:0]   wide_t;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitCal = 3'd1,
        StWaitArp = 3'd2,
        StRun     = 3'd3,
        StFault   = 3'd4
    } state_e;

    localparam logic [1:0] FaultNone = 2'd0;
    localparam logic [1:0] FaultAcp  = 2'd1;
    localparam logic [1:0] FaultArp  = 2'd2;
    localparam logic [1:0] FaultTrig = 2'd3;

    state_e     state_q;
    logic       running_q;
    logic       turn_start_q;
    logic       sweep_start_q;
    word_t      azimuth_q;
    word_t      sweep_az_q;
    word_t      sweep_idx_q;
    logic [1:0] fault_code_q;
    word_t      sweep_cnt_q;
    word_t      us_since_arp_q;
    word_t      us_since_trig_q;
    logic [3:0] cal_cnt_q;
    word_t      ref_arp_q;
    word_t      ref_acp_q;
    word_t      ref_trig_q;

    word_t acp_lo;
    wide_t acp_hi;
    wide_t arp_limit;
    wide_t trig_limit;
    wide_t az_inc;
    word_t az_nxt;
    word_t sweep_base;
    word_t us_arp_nxt;
    word_t us_trig_nxt;
    logic  arp_bad;
    logic  acp_over;
    logic  arp_lost;
    logic  trig_lost;

    function automatic word_t sat_inc(input word_t v, input logic tick);
        return (tick && (v != '1)) ? v + word_t'(1) : v;
    endfunction

    // Next-cycle azimuth/watchdog values and the fault windows derived from the references.
    always_comb begin
        acp_lo      = (ref_acp_q >= word_t'(ACP_TOL)) ? ref_acp_q - word_t'(ACP_TOL) : '0;
        acp_hi      = wide_t'(ref_acp_q) + wide_t'(ACP_TOL);
        arp_limit   = wide_t'(ref_arp_q) + wide_t'(ref_arp_q >> 3);
        trig_limit  = {ref_trig_q, 1'b0};
        az_inc      = wide_t'(azimuth_q) + wide_t'(1);
        az_nxt      = azimuth_q;
        if (ARP_PULSE) begin
            az_nxt = word_t'(ACP_PULSE);
        end else if (ACP_PULSE) begin
            az_nxt = azimuth_q + word_t'(1);
        end
        sweep_base  = ARP_PULSE ? '0 : sweep_cnt_q;
        us_arp_nxt  = ARP_PULSE ? word_t'(US_TICK) : sat_inc(us_since_arp_q, US_TICK);
        us_trig_nxt = TRIG_PULSE ? word_t'(US_TICK) : sat_inc(us_since_trig_q, US_TICK);
        // Pre-ARP azimuth is the number of ACPs seen in the turn that just ended.
        arp_bad     = ARP_PULSE && ((wide_t'(azimuth_q) > acp_hi) || (azimuth_q < acp_lo));
        acp_over    = !ARP_PULSE && ACP_PULSE && (az_inc > acp_hi);
        arp_lost    = wide_t'(us_arp_nxt) > arp_limit;
        trig_lost   = wide_t'(us_trig_nxt) > trig_limit;
    end

    // Run-control FSM with registered outputs, counters and latched references.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RESETN) begin
            state_q         <= StIdle;
            running_q       <= 1'b0;
            turn_start_q    <= 1'b0;
            sweep_start_q   <= 1'b0;
            azimuth_q       <= '0;
            sweep_az_q      <= '0;
            sweep_idx_q     <= '0;
            fault_code_q    <= FaultNone;
            sweep_cnt_q     <= '0;
            us_since_arp_q  <= '0;
            us_since_trig_q <= '0;
            cal_cnt_q       <= '0;
            ref_arp_q       <= '0;
            ref_acp_q       <= '0;
            ref_trig_q      <= '0;
        end else begin
            turn_start_q  <= 1'b0;
            sweep_start_q <= 1'b0;
            running_q     <= 1'b0;
            if (!ENABLE) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q      <= StWaitCal;
                        fault_code_q <= FaultNone;
                        cal_cnt_q    <= '0;
                    end
                    StWaitCal: begin
                        if (ARP_PULSE) begin
                            if (CALIBRATED) begin
                                cal_cnt_q <= cal_cnt_q + 4'd1;
                                if (cal_cnt_q + 4'd1 == 4'(CAL_TURNS)) begin
                                    state_q    <= StWaitArp;
                                    ref_arp_q  <= ARP_US;
                                    ref_acp_q  <= ACP_CNT;
                                    ref_trig_q <= TRIG_US;
                                end
                            end else begin
                                cal_cnt_q <= '0;
                            end
                        end
                    end
                    StWaitArp: begin
                        // Entry ARP: turn reset without the ACP count check.
                        if (ARP_PULSE) begin
                            state_q         <= StRun;
                            running_q       <= 1'b1;
                            turn_start_q    <= 1'b1;
                            azimuth_q       <= az_nxt;
                            us_since_arp_q  <= word_t'(US_TICK);
                            us_since_trig_q <= word_t'(US_TICK);
                            sweep_cnt_q     <= TRIG_PULSE ? word_t'(1) : '0;
                            if (TRIG_PULSE) begin
                                sweep_start_q <= 1'b1;
                                sweep_az_q    <= az_nxt;
                                sweep_idx_q   <= '0;
                            end
                        end
                    end
                    StRun: begin
                        if (arp_bad || acp_over) begin
                            state_q      <= StFault;
                            fault_code_q <= FaultAcp;
                        end else if (arp_lost) begin
                            state_q      <= StFault;
                            fault_code_q <= FaultArp;
                        end else if (trig_lost) begin
                            state_q      <= StFault;
                            fault_code_q <= FaultTrig;
                        end else begin
                            running_q       <= 1'b1;
                            turn_start_q    <= ARP_PULSE;
                            azimuth_q       <= az_nxt;
                            us_since_arp_q  <= us_arp_nxt;
                            us_since_trig_q <= us_trig_nxt;
                            if (TRIG_PULSE) begin
                                sweep_start_q <= 1'b1;
                                sweep_az_q    <= az_nxt;
                                sweep_idx_q   <= sweep_base;
                                sweep_cnt_q   <= sweep_base + word_t'(1);
                            end else begin
                                sweep_cnt_q   <= sweep_base;
                            end
                        end
                    end
                    StFault: begin
                        // Frozen until ENABLE drops.
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign STATE       = state_q;
    assign RUNNING     = running_q;
    assign TURN_START  = turn_start_q;
    assign SWEEP_START = sweep_start_q;
    assign AZIMUTH     = azimuth_q;
    assign SWEEP_AZ    = sweep_az_q;
    assign SWEEP_IDX   = sweep_idx_q;
    assign FAULT_CODE  = fault_code_q;

endmodule

// File: tb/tb_radar_sim_sequencer.sv
// Directed bench for radar_sim_sequencer: bring-up, calibration loss,
// ACP/ARP/TRIG faults, simultaneous events, reset and ENABLE handling.
module tb_radar_sim_sequencer;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RESETN;
    logic        ENABLE;
    logic        ARP_PULSE;
    logic        ACP_PULSE;
    logic        TRIG_PULSE;
    logic        US_TICK;
    logic        CALIBRATED;
    logic [31:0] ARP_US;
    logic [31:0] ACP_CNT;
    logic [31:0] TRIG_US;
    logic [2:0]  STATE;
    logic        RUNNING;
    logic        TURN_START;
    logic        SWEEP_START;
    logic [31:0] AZIMUTH;
    logic [31:0] SWEEP_AZ;
    logic [31:0] SWEEP_IDX;
    logic [1:0]  FAULT_CODE;

    int checks = 0;
    int errors = 0;
    int exp_az = 0;

    always #5 SYS_CLK = ~SYS_CLK;

    radar_sim_sequencer #(
        .DATA_WIDTH (32),
        .CAL_TURNS  (2),
        .ACP_TOL    (1)
    ) dut (
        .SYS_CLK     (SYS_CLK),
        .SYS_RESETN  (SYS_RESETN),
        .ENABLE      (ENABLE),
        .ARP_PULSE   (ARP_PULSE),
        .ACP_PULSE   (ACP_PULSE),
        .TRIG_PULSE  (TRIG_PULSE),
        .US_TICK     (US_TICK),
        .CALIBRATED  (CALIBRATED),
        .ARP_US      (ARP_US),
        .ACP_CNT     (ACP_CNT),
        .TRIG_US     (TRIG_US),
        .STATE       (STATE),
        .RUNNING     (RUNNING),
        .TURN_START  (TURN_START),
        .SWEEP_START (SWEEP_START),
        .AZIMUTH     (AZIMUTH),
        .SWEEP_AZ    (SWEEP_AZ),
        .SWEEP_IDX   (SWEEP_IDX),
        .FAULT_CODE  (FAULT_CODE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive pulses, let the edge consume them, sample 1 ns later.
    task automatic step(input bit arp, input bit acp, input bit trig, input bit tick);
        ARP_PULSE  = arp;
        ACP_PULSE  = acp;
        TRIG_PULSE = trig;
        US_TICK    = tick;
        @(posedge SYS_CLK);
        #1;
        ARP_PULSE  = 1'b0;
        ACP_PULSE  = 1'b0;
        TRIG_PULSE = 1'b0;
        US_TICK    = 1'b0;
    endtask

    function automatic bit acp_at(input int k, input int n);
        bit even_slot;
        bit extra_slot;
        even_slot  = (k < 1000) && (k % 62 == 31) && (k / 62 < n);
        extra_slot = (n > 16) && (k >= 970) && (k < 970 + 10 * (n - 16)) && ((k - 970) % 10 == 0);
        return even_slot || extra_slot;
    endfunction

    // Turn starting with ARP at k=0, US_TICK every cycle, TRIG at k=50+100j.
    task automatic turn(input int n_acp, input int n_trig, input int len, input bit chk);
        for (int k = 0; k < len; k++) begin
            bit a;
            bit c;
            bit t;
            a = (k == 0);
            c = acp_at(k, n_acp);
            t = (k % 100 == 50) && (k / 100 < n_trig);
            step(a, c, t, 1'b1);
            if (a) exp_az = int'(c);
            else if (c) exp_az++;
            if (chk && a) check("turn_start", 32'(TURN_START), 32'd1);
            if (chk && t) begin
                check("sweep_start", 32'(SWEEP_START), 32'd1);
                check("sweep_idx", SWEEP_IDX, 32'(k / 100));
                check("sweep_az", SWEEP_AZ, 32'(exp_az));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(STATE), 32'd0);
        check({tag, "_running"}, 32'(RUNNING), 32'd0);
        check({tag, "_turn_start"}, 32'(TURN_START), 32'd0);
        check({tag, "_sweep_start"}, 32'(SWEEP_START), 32'd0);
        check({tag, "_azimuth"}, AZIMUTH, 32'd0);
        check({tag, "_sweep_az"}, SWEEP_AZ, 32'd0);
        check({tag, "_sweep_idx"}, SWEEP_IDX, 32'd0);
        check({tag, "_fault_code"}, 32'(FAULT_CODE), 32'd0);
    endtask

    initial begin
        SYS_RESETN = 1'b0;
        ENABLE     = 1'b0;
        ARP_PULSE  = 1'b0;
        ACP_PULSE  = 1'b0;
        TRIG_PULSE = 1'b0;
        US_TICK    = 1'b0;
        CALIBRATED = 1'b1;
        ARP_US     = 32'd1000;
        ACP_CNT    = 32'd16;
        TRIG_US    = 32'd100;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("reset");
        SYS_RESETN = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_disabled", 32'(STATE), 32'd0);

        // Bring-up: first ARP lands in IDLE, two calibrated ARPs, then entry.
        ENABLE = 1'b1;
        turn(16, 10, 1000, 1'b0);
        check("bringup_wait_cal", 32'(STATE), 32'd1);
        turn(16, 10, 1000, 1'b0);
        check("bringup_cal1", 32'(STATE), 32'd1);
        turn(16, 10, 1000, 1'b0);
        check("bringup_wait_arp", 32'(STATE), 32'd2);
        turn(16, 10, 1000, 1'b1);
        check("bringup_run", 32'(STATE), 32'd3);
        check("bringup_running", 32'(RUNNING), 32'd1);
        check("bringup_az_end1", AZIMUTH, 32'd16);
        turn(16, 10, 1000, 1'b1);
        check("bringup_az_end2", AZIMUTH, 32'd16);
        check("bringup_fault", 32'(FAULT_CODE), 32'd0);

        // ARP, ACP, TRIG and US_TICK together.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("simul_turn_start", 32'(TURN_START), 32'd1);
        check("simul_sweep_start", 32'(SWEEP_START), 32'd1);
        check("simul_azimuth", AZIMUTH, 32'd1);
        check("simul_sweep_az", SWEEP_AZ, 32'd1);
        check("simul_sweep_idx", SWEEP_IDX, 32'd0);
        check("simul_state", 32'(STATE), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("strobe_len_turn", 32'(TURN_START), 32'd0);
        check("strobe_len_sweep", 32'(SWEEP_START), 32'd0);

        // One-cycle reset mid-RUN.
        SYS_RESETN = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_all_zero("midrun_reset");
        SYS_RESETN = 1'b1;

        // Calibration drop resets the count.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("cal_wait_cal", 32'(STATE), 32'd1);
        turn(0, 0, 50, 1'b0);
        CALIBRATED = 1'b0;
        turn(0, 0, 50, 1'b0);
        CALIBRATED = 1'b1;
        turn(0, 0, 50, 1'b0);
        check("cal_restart", 32'(STATE), 32'd1);
        turn(0, 0, 50, 1'b0);
        check("cal_armed", 32'(STATE), 32'd2);

        // Short turn: 14 ACPs then ARP.
        turn(14, 10, 1000, 1'b1);
        check("short_run", 32'(STATE), 32'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("short_state", 32'(STATE), 32'd4);
        check("short_code", 32'(FAULT_CODE), 32'd1);
        check("short_no_turn", 32'(TURN_START), 32'd0);
        check("short_running", 32'(RUNNING), 32'd0);
        check("short_az_frozen", AZIMUTH, 32'd14);

        // ENABLE low in FAULT holds the code; ENABLE high clears it.
        ENABLE = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("dis_state", 32'(STATE), 32'd0);
        check("dis_code_held", 32'(FAULT_CODE), 32'd1);
        ENABLE = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("en_state", 32'(STATE), 32'd1);
        check("en_code_clr", 32'(FAULT_CODE), 32'd0);

        // 18th ACP faults immediately.
        turn(0, 0, 50, 1'b0);
        turn(0, 0, 50, 1'b0);
        check("over_armed", 32'(STATE), 32'd2);
        turn(18, 10, 980, 1'b1);
        check("over_17_ok", 32'(STATE), 32'd3);
        check("over_17_az", AZIMUTH, 32'd17);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("over_state", 32'(STATE), 32'd4);
        check("over_code", 32'(FAULT_CODE), 32'd1);
        check("over_az_frozen", AZIMUTH, 32'd17);

        // ARP lost at 1126 us.
        ENABLE = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ENABLE = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        turn(0, 0, 50, 1'b0);
        turn(0, 0, 50, 1'b0);
        turn(16, 20, 1125, 1'b1);
        check("arplost_1125", 32'(STATE), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("arplost_state", 32'(STATE), 32'd4);
        check("arplost_code", 32'(FAULT_CODE), 32'd2);

        // TRIG lost at 201 us after the last TRIG.
        ENABLE = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ENABLE = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        turn(0, 0, 50, 1'b0);
        turn(0, 0, 50, 1'b0);
        turn(16, 1, 250, 1'b1);
        check("triglost_200", 32'(STATE), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("triglost_state", 32'(STATE), 32'd4);
        check("triglost_code", 32'(FAULT_CODE), 32'd3);
        check("triglost_no_strobe", 32'(SWEEP_START), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
